// File: rtl/register_readout_serializer_pkg.sv
// Shared types and sizing helpers for the register readout serializer.
// Optional feature macro used by the top: READOUT_PARITY_EN.
package readout_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  function automatic int beats_f(input int width, input int chunk);
    return (width + chunk - 32'sd1) / chunk;
  endfunction

  // A single-beat word still gets a 1-bit counter so port widths stay legal.
  function automatic int cnt_width_f(input int beats);
    if (beats <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(beats);
    end
  endfunction

endpackage

// File: rtl/register_readout_serializer_beat_counter.sv
// Beat index counter for the readout serializer: clear, increment, and a
// registered terminal-count flag raised when the count reaches BEATS-1.
module readout_beat_counter
  import readout_pkg::*;
#(
  parameter int BEATS = 4,
  parameter int CW    = cnt_width_f(BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          tc_r;

  // Next count: saturates at the terminal value so it never passes BEATS-1.
  always_comb begin
    count_nxt_s = count_r;
    if (clear) begin
      count_nxt_s = '0;
    end else if (inc && !tc_r) begin
      count_nxt_s = count_r + CW'(1'b1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count and terminal-count flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
      tc_r    <= (BEATS == 32'sd1);
    end else begin
      count_r <= count_nxt_s;
      tc_r    <= (count_nxt_s == CW'(BEATS - 32'sd1));
    end
  end

  assign count = count_r;
  assign tc    = tc_r;

endmodule

// File: rtl/register_readout_serializer.sv
// Captures a WIDTH-bit word on a load handshake and streams it LSB chunk first
// as CHUNK-bit valid/ready beats. READOUT_PARITY_EN adds a registered out_parity.
module register_readout_serializer
  import readout_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHUNK-1:0] out_data,
  output logic             out_last,
  output logic             busy
`ifdef READOUT_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int BEATS = beats_f(WIDTH, CHUNK);
  localparam int CW    = cnt_width_f(BEATS);

  state_e           state_r, state_nxt_s;
  logic [WIDTH-1:0] shadow_r, shadow_nxt_s;
  logic [CHUNK-1:0] data_nxt_s, out_data_r;
  logic             last_nxt_s, out_last_r;
  logic             out_valid_r, busy_r, load_ready_r;
  logic             cnt_clr_s, cnt_inc_s, near_tc_s;
  logic [CW-1:0]    cnt_s;
  logic             tc_s;

  readout_beat_counter #(
    .BEATS (BEATS),
    .CW    (CW)
  ) u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clr_s),
    .inc   (cnt_inc_s),
    .count (cnt_s),
    .tc    (tc_s)
  );

  // The beat after the next transfer is the final one.
  assign near_tc_s = (BEATS > 32'sd1) && (cnt_s == CW'(BEATS - 32'sd2));

  // FSM next state, shadow update and next-cycle output values.
  always_comb begin
    state_nxt_s  = state_r;
    shadow_nxt_s = shadow_r;
    cnt_clr_s    = 1'b0;
    cnt_inc_s    = 1'b0;
    last_nxt_s   = out_last_r;
    data_nxt_s   = '0;
    case (state_r)
      ST_IDLE: begin
        if (load_valid && load_ready_r) begin
          state_nxt_s  = ST_SEND;
          shadow_nxt_s = load_data;
          cnt_clr_s    = 1'b1;
          last_nxt_s   = (BEATS == 32'sd1);
        end else begin
          last_nxt_s   = 1'b0;
        end
      end
      ST_SEND: begin
        if (out_valid_r && out_ready) begin
          if (tc_s) begin
            state_nxt_s  = ST_IDLE;
            last_nxt_s   = 1'b0;
          end else begin
            shadow_nxt_s = shadow_r >> CHUNK;
            cnt_inc_s    = 1'b1;
            last_nxt_s   = near_tc_s;
          end
        end else begin
          last_nxt_s   = out_last_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        last_nxt_s  = 1'b0;
      end
    endcase
    if (state_nxt_s == ST_SEND) begin
      data_nxt_s = shadow_nxt_s[CHUNK-1:0];
    end else begin
      data_nxt_s = '0;
    end
  end

  // State, shadow word and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      shadow_r     <= '0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      load_ready_r <= 1'b0;
      out_data_r   <= '0;
      out_last_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      shadow_r     <= shadow_nxt_s;
      out_valid_r  <= (state_nxt_s == ST_SEND);
      busy_r       <= (state_nxt_s == ST_SEND);
      load_ready_r <= (state_nxt_s == ST_IDLE);
      out_data_r   <= data_nxt_s;
      out_last_r   <= last_nxt_s;
    end
  end

`ifdef READOUT_PARITY_EN
  logic parity_r;

  function automatic logic even_parity_f(input logic [CHUNK-1:0] d);
    return ^d;
  endfunction

  // Parity travels with out_data, so it holds under backpressure too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= even_parity_f(data_nxt_s);
    end
  end

  assign out_parity = parity_r;
`endif

  assign load_ready = load_ready_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_last   = out_last_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_register_readout_serializer.sv
// Directed bench: a 32/8 instance and a 12/8 instance with hand-computed beats.
// Build once with and once without +define+READOUT_PARITY_EN.
module tb_register_readout_serializer;

  logic        clk;
  logic        rst;

  logic        a_load_valid, a_load_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [31:0] a_load_data;
  logic [7:0]  a_out_data;

  logic        b_load_valid, b_load_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [11:0] b_load_data;
  logic [7:0]  b_out_data;

`ifdef READOUT_PARITY_EN
  logic        a_par, b_par;
`endif

  int n_cmp = 0;
  int n_err = 0;

  register_readout_serializer #(.WIDTH(32), .CHUNK(8)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .load_valid (a_load_valid),
    .load_ready (a_load_ready),
    .load_data  (a_load_data),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_data   (a_out_data),
    .out_last   (a_out_last),
    .busy       (a_busy)
`ifdef READOUT_PARITY_EN
    ,
    .out_parity (a_par)
`endif
  );

  register_readout_serializer #(.WIDTH(12), .CHUNK(8)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .load_valid (b_load_valid),
    .load_ready (b_load_ready),
    .load_data  (b_load_data),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_data   (b_out_data),
    .out_last   (b_out_last),
    .busy       (b_busy)
`ifdef READOUT_PARITY_EN
    ,
    .out_parity (b_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic beat_a(input string tag, input logic [7:0] d, input logic last, input logic par);
    check_eq({tag, ".valid"}, 32'(a_out_valid), 32'h1);
    check_eq({tag, ".data"}, 32'(a_out_data), 32'(d));
    check_eq({tag, ".last"}, 32'(a_out_last), 32'(last));
    check_eq({tag, ".busy"}, 32'(a_busy), 32'h1);
    check_eq({tag, ".ldrdy"}, 32'(a_load_ready), 32'h0);
`ifdef READOUT_PARITY_EN
    check_eq({tag, ".par"}, 32'(a_par), 32'(par));
`else
    if (par === 1'bx) $display("unexpected X parity argument in %s", tag);
`endif
  endtask

  task automatic beat_b(input string tag, input logic [7:0] d, input logic last, input logic par);
    check_eq({tag, ".valid"}, 32'(b_out_valid), 32'h1);
    check_eq({tag, ".data"}, 32'(b_out_data), 32'(d));
    check_eq({tag, ".last"}, 32'(b_out_last), 32'(last));
`ifdef READOUT_PARITY_EN
    check_eq({tag, ".par"}, 32'(b_par), 32'(par));
`else
    if (par === 1'bx) $display("unexpected X parity argument in %s", tag);
`endif
  endtask

  task automatic idle_a(input string tag);
    check_eq({tag, ".valid"}, 32'(a_out_valid), 32'h0);
    check_eq({tag, ".busy"}, 32'(a_busy), 32'h0);
    check_eq({tag, ".ldrdy"}, 32'(a_load_ready), 32'h1);
  endtask

  initial begin
    rst = 1'b0;
    a_load_valid = 1'b0; a_load_data = 32'h0; a_out_ready = 1'b0;
    b_load_valid = 1'b0; b_load_data = 12'h0; b_out_ready = 1'b0;

    // reset state
    tick;
    check_eq("rst.ldrdy", 32'(a_load_ready), 32'h0);
    check_eq("rst.valid", 32'(a_out_valid), 32'h0);
    check_eq("rst.data", 32'(a_out_data), 32'h0);
    check_eq("rst.last", 32'(a_out_last), 32'h0);
    check_eq("rst.busy", 32'(a_busy), 32'h0);
`ifdef READOUT_PARITY_EN
    check_eq("rst.par", 32'(a_par), 32'h0);
`endif
    rst = 1'b1;
    tick;
    idle_a("rel");
    check_eq("rel.b_ldrdy", 32'(b_load_ready), 32'h1);

    // 1: full-rate stream
    a_load_valid = 1'b1; a_load_data = 32'hA1B2C3D4; a_out_ready = 1'b1;
    tick;
    a_load_valid = 1'b0;
    beat_a("t1.b0", 8'hD4, 1'b0, 1'b0); tick;
    beat_a("t1.b1", 8'hC3, 1'b0, 1'b0); tick;
    beat_a("t1.b2", 8'hB2, 1'b0, 1'b0); tick;
    beat_a("t1.b3", 8'hA1, 1'b1, 1'b1); tick;
    idle_a("t1.end");

    // 2: backpressure on beat 1
    a_load_valid = 1'b1;
    tick;
    a_load_valid = 1'b0;
    beat_a("t2.b0", 8'hD4, 1'b0, 1'b0); tick;
    beat_a("t2.b1", 8'hC3, 1'b0, 1'b0);
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      beat_a("t2.hold", 8'hC3, 1'b0, 1'b0);
    end
    a_out_ready = 1'b1;
    tick;
    beat_a("t2.b2", 8'hB2, 1'b0, 1'b0); tick;
    beat_a("t2.b3", 8'hA1, 1'b1, 1'b1); tick;
    idle_a("t2.end");

    // 4: load during SEND is ignored
    a_load_valid = 1'b1; a_load_data = 32'hA1B2C3D4;
    tick;
    a_load_data = 32'h11111111;
    beat_a("t4.b0", 8'hD4, 1'b0, 1'b0); tick;
    beat_a("t4.b1", 8'hC3, 1'b0, 1'b0); tick;
    beat_a("t4.b2", 8'hB2, 1'b0, 1'b0); tick;
    beat_a("t4.b3", 8'hA1, 1'b1, 1'b1); tick;
    idle_a("t4.gap");
    tick;
    a_load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat_a("t4.new", 8'h11, (i == 3), 1'b0);
      tick;
    end
    idle_a("t4.end");

    // 5: async reset mid-word
    a_load_valid = 1'b1; a_load_data = 32'hA1B2C3D4;
    tick;
    a_load_valid = 1'b0;
    beat_a("t5.b0", 8'hD4, 1'b0, 1'b0); tick;
    beat_a("t5.b1", 8'hC3, 1'b0, 1'b0); tick;
    beat_a("t5.b2", 8'hB2, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    check_eq("t5.rst.valid", 32'(a_out_valid), 32'h0);
    check_eq("t5.rst.data", 32'(a_out_data), 32'h0);
    check_eq("t5.rst.busy", 32'(a_busy), 32'h0);
    check_eq("t5.rst.ldrdy", 32'(a_load_ready), 32'h0);
    tick;
    rst = 1'b1;
    tick;
    idle_a("t5.rel");
    tick;
    idle_a("t5.quiet");
    a_load_valid = 1'b1; a_load_data = 32'h55667788;
    tick;
    a_load_valid = 1'b0;
    beat_a("t5.n0", 8'h88, 1'b0, 1'b0); tick;
    beat_a("t5.n1", 8'h77, 1'b0, 1'b0); tick;
    beat_a("t5.n2", 8'h66, 1'b0, 1'b0); tick;
    beat_a("t5.n3", 8'h55, 1'b1, 1'b0); tick;
    idle_a("t5.end");

    // 3: WIDTH=12 with zero-padded last beat
    b_out_ready = 1'b1; b_load_valid = 1'b1; b_load_data = 12'hABC;
    tick;
    b_load_valid = 1'b0;
    beat_b("t3.b0", 8'hBC, 1'b0, 1'b1); tick;
    beat_b("t3.b1", 8'h0A, 1'b1, 1'b0); tick;
    check_eq("t3.end.valid", 32'(b_out_valid), 32'h0);
    check_eq("t3.end.ldrdy", 32'(b_load_ready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
